// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared state encoding, BCD digit type and digit limits for the
//            stopwatch sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t HS_MAX       = 4'd9;
    localparam bcd_t TENS_SEC_MAX = 4'd5;
    localparam bcd_t TENS_MIN_MAX = 4'd5;

    // Treating anything at or above the limit as terminal keeps a digit BCD
    // even if it were ever disturbed into an illegal code.
    function automatic logic bcd_at_max(input bcd_t d, input bcd_t lim);
        return (d >= lim);
    endfunction

    function automatic bcd_t bcd_next(input bcd_t d, input bcd_t lim);
        return bcd_at_max(d, lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync_edge
// Purpose  : Raw push-button conditioning: 2-flop synchronizer, rising-edge
//            detect and a post-event lockout that swallows contact bounce.
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
    parameter int DEBOUNCE = 2_000_000
) (
    input  logic clock_in,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_event
);

    localparam int c_lock_w = $clog2(DEBOUNCE + 1);
    localparam logic [c_lock_w-1:0] c_lock_load = c_lock_w'(DEBOUNCE);
    localparam logic [c_lock_w-1:0] c_lock_one  = c_lock_w'(1);

    logic [1:0]          r_sync;
    logic                r_prev;
    logic [c_lock_w-1:0] r_lockout;
    logic                w_rise;

    assign w_rise    = r_sync[1] & ~r_prev;
    assign btn_event = w_rise & (r_lockout == '0);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_sync    <= 2'b00;
            r_prev    <= 1'b0;
            r_lockout <= '0;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
            r_prev <= r_sync[1];
            if (btn_event) begin
                r_lockout <= c_lock_load;
            end else if (r_lockout != '0) begin
                r_lockout <= r_lockout - c_lock_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : IDLE/RUN/PAUSE sequencer with hundredth-second prescaler and a
//            six-digit BCD MM:SS.hh cascade; drives the display divider enable.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int DEBOUNCE = 2_000_000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    output logic       running,
    output logic       div_enable,
    output logic       tick,
    output logic [3:0] hs_ones,
    output logic [3:0] hs_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       overflow
);

    localparam int c_pre_w = $clog2(TICK_DIV);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);

    sw_state_t          r_state;
    sw_state_t          w_state_next;
    logic               w_clear_all;
    logic               w_ss_event;
    logic               w_clr_event;
    logic [c_pre_w-1:0] r_prescale;
    logic               w_wrap;
    logic               r_tick;
    logic               r_running;
    logic               r_overflow;
    bcd_t               r_hs_ones, r_hs_tens, r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
    logic               w_c_hs_tens, w_c_sec_ones, w_c_sec_tens, w_c_min_ones, w_c_min_tens, w_c_all;

    btn_sync_edge #(.DEBOUNCE(DEBOUNCE)) u_btn_start_stop (
        .clock_in  (clock_in),
        .reset     (reset),
        .btn_raw   (start_stop),
        .btn_event (w_ss_event)
    );

    btn_sync_edge #(.DEBOUNCE(DEBOUNCE)) u_btn_clear (
        .clock_in  (clock_in),
        .reset     (reset),
        .btn_raw   (clear),
        .btn_event (w_clr_event)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_running <= (w_state_next == RUN);
        end
    end

    // Clear beats start_stop outside RUN; inside RUN only start_stop matters.
    always_comb begin
        w_state_next = r_state;
        w_clear_all  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_clr_event && w_ss_event) w_state_next = RUN;
            end
            RUN: begin
                if (w_ss_event) w_state_next = PAUSE;
            end
            PAUSE: begin
                if (w_clr_event) begin
                    w_state_next = IDLE;
                    w_clear_all  = 1'b1;
                end else if (w_ss_event) begin
                    w_state_next = RUN;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_wrap = (r_state == RUN) && (r_prescale == c_pre_last);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (w_clear_all || (r_state == IDLE)) begin
                r_prescale <= '0;
            end else if (r_state == RUN) begin
                r_prescale <= w_wrap ? '0 : r_prescale + c_pre_one;
            end
        end
    end

    assign w_c_hs_tens  = bcd_at_max(r_hs_ones, HS_MAX);
    assign w_c_sec_ones = w_c_hs_tens  && bcd_at_max(r_hs_tens, HS_MAX);
    assign w_c_sec_tens = w_c_sec_ones && bcd_at_max(r_sec_ones, HS_MAX);
    assign w_c_min_ones = w_c_sec_tens && bcd_at_max(r_sec_tens, TENS_SEC_MAX);
    assign w_c_min_tens = w_c_min_ones && bcd_at_max(r_min_ones, HS_MAX);
    assign w_c_all      = w_c_min_tens && bcd_at_max(r_min_tens, TENS_MIN_MAX);

    // Digits are only written on a tick or a clear, otherwise they hold.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_hs_ones  <= 4'd0;
            r_hs_tens  <= 4'd0;
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_overflow <= 1'b0;
        end else if (w_clear_all) begin
            r_hs_ones  <= 4'd0;
            r_hs_tens  <= 4'd0;
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_overflow <= 1'b0;
        end else if (w_wrap) begin
            r_hs_ones <= bcd_next(r_hs_ones, HS_MAX);
            if (w_c_hs_tens)  r_hs_tens  <= bcd_next(r_hs_tens, HS_MAX);
            if (w_c_sec_ones) r_sec_ones <= bcd_next(r_sec_ones, HS_MAX);
            if (w_c_sec_tens) r_sec_tens <= bcd_next(r_sec_tens, TENS_SEC_MAX);
            if (w_c_min_ones) r_min_ones <= bcd_next(r_min_ones, HS_MAX);
            if (w_c_min_tens) r_min_tens <= bcd_next(r_min_tens, TENS_MIN_MAX);
            if (w_c_all)      r_overflow <= 1'b1;
        end
    end

    assign running    = r_running;
    assign div_enable = r_running;
    assign tick       = r_tick;
    assign hs_ones    = r_hs_ones;
    assign hs_tens    = r_hs_tens;
    assign sec_ones   = r_sec_ones;
    assign sec_tens   = r_sec_tens;
    assign min_ones   = r_min_ones;
    assign min_tens   = r_min_tens;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Directed plus randomized bench for stopwatch_ctrl against a
//            time-in-hundredths reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DEBOUNCE = 8;
    localparam int WRAP_T   = 360000;

    logic       clock_in = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       running;
    logic       div_enable;
    logic       tick;
    logic [3:0] hs_ones, hs_tens, sec_ones, sec_tens, min_ones, min_tens;
    logic       overflow;

    always #5 clock_in = ~clock_in;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .running    (running),
        .div_enable (div_enable),
        .tick       (tick),
        .hs_ones    (hs_ones),
        .hs_tens    (hs_tens),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .overflow   (overflow)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: state as 0=idle 1=run 2=pause, elapsed time in hundredths.
    int   m_state, m_pre, m_t, edge_n;
    logic m_tick, m_ovf;
    logic ss1, ss2, ss3, clr1, clr2, clr3;
    int   ss_last, clr_last;

    function automatic logic [23:0] digs();
        return {min_tens, min_ones, sec_tens, sec_ones, hs_tens, hs_ones};
    endfunction

    function automatic logic [27:0] dut_vec();
        return {running, div_enable, tick, overflow, digs()};
    endfunction

    function automatic logic [23:0] exp_digs();
        int hs, sec, mn;
        hs  = m_t % 100;
        sec = (m_t / 100) % 60;
        mn  = m_t / 6000;
        return {4'(mn / 10), 4'(mn % 10), 4'(sec / 10), 4'(sec % 10), 4'(hs / 10), 4'(hs % 10)};
    endfunction

    function automatic logic [27:0] exp_vec();
        logic r;
        r = (m_state == 1);
        return {r, r, m_tick, m_ovf, exp_digs()};
    endfunction

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {27'd0, obs}, {27'd0, exp});
    endtask

    task automatic model_reset();
        m_state = 0; m_pre = 0; m_t = 0; m_tick = 1'b0; m_ovf = 1'b0;
        ss1 = 1'b0; ss2 = 1'b0; ss3 = 1'b0;
        clr1 = 1'b0; clr2 = 1'b0; clr3 = 1'b0;
        ss_last = -100; clr_last = -100;
    endtask

    // A button level reaches the FSM three edges after it is sampled; accepted
    // events must be more than DEBOUNCE edges apart.
    task automatic model_edge(input logic ss_raw, input logic clr_raw);
        logic ss_ev, clr_ev;
        int   old;
        edge_n++;
        ss_ev  = ss2 && !ss3 && (edge_n - ss_last > DEBOUNCE);
        clr_ev = clr2 && !clr3 && (edge_n - clr_last > DEBOUNCE);
        if (ss_ev)  ss_last  = edge_n;
        if (clr_ev) clr_last = edge_n;
        ss3 = ss2; ss2 = ss1; ss1 = ss_raw;
        clr3 = clr2; clr2 = clr1; clr1 = clr_raw;
        old = m_state;
        m_tick = 1'b0;
        if (old == 1) begin
            m_pre++;
            if (m_pre == TICK_DIV) begin
                m_pre  = 0;
                m_tick = 1'b1;
                m_t++;
                if (m_t == WRAP_T) begin
                    m_t   = 0;
                    m_ovf = 1'b1;
                end
            end
        end else if (old == 0) begin
            m_pre = 0;
        end
        case (old)
            0: if (ss_ev && !clr_ev) m_state = 1;
            1: if (ss_ev) m_state = 2;
            default: begin
                if (clr_ev) begin
                    m_state = 0; m_pre = 0; m_t = 0; m_ovf = 1'b0;
                end else if (ss_ev) begin
                    m_state = 1;
                end
            end
        endcase
    endtask

    task automatic cycle(input logic ss, input logic clr);
        @(negedge clock_in);
        start_stop = ss;
        clear      = clr;
        @(posedge clock_in);
        #1;
        if (reset) model_reset();
        else       model_edge(ss, clr);
        check($sformatf("cycle%0d", edge_n), dut_vec(), exp_vec());
    endtask

    task automatic hold(input logic ss, input logic clr, input int n);
        for (int i = 0; i < n; i++) cycle(ss, clr);
    endtask

    task automatic press_ss();
        hold(1'b0, 1'b0, DEBOUNCE + 2);
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, DEBOUNCE + 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        int          ticks;
        logic        seen;
        logic [23:0] paused;
        int          r;
        int          n;

        reset = 1'b1; start_stop = 1'b0; clear = 1'b0;
        edge_n = 0;
        model_reset();
        hold(1'b0, 1'b0, 2);
        reset = 1'b0;

        // Start latency, first tick and 40 hundredths.
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check_bit("start_not_yet_edge2", running, 1'b0);
        cycle(1'b0, 1'b0);
        check_bit("start_on_edge3", running, 1'b1);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1'b0, 1'b0);
            cnt++;
            if (tick) seen = 1'b1;
        end
        check("first_tick_latency", 28'(cnt), 28'd4);
        ticks = 1;
        for (int i = 0; i < 400 && ticks < 40; i++) begin
            cycle(1'b0, 1'b0);
            if (tick) ticks++;
        end
        check("digits_after_40", {4'h0, digs()}, {4'h0, 24'h000040});

        // Bounce inside lockout from PAUSE gives one event.
        press_ss();
        check_bit("paused_before_bounce", running, 1'b0);
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, 1);
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, DEBOUNCE + 4);
        check_bit("bounce_single_event", running, 1'b1);

        // Pause with prescaler held at 2, resume keeps the fraction.
        for (int i = 0; i < 8 && m_pre != 3; i++) cycle(1'b0, 1'b0);
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, 2);
        check_bit("pause_taken", running, 1'b0);
        paused = exp_digs();
        hold(1'b0, 1'b0, 50);
        check("digits_hold_in_pause", {4'h0, digs()}, {4'h0, paused});
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, 2);
        check_bit("resume_taken", running, 1'b1);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1'b0, 1'b0);
            cnt++;
            if (tick) seen = 1'b1;
        end
        check("tick_after_resume", 28'(cnt), 28'd2);

        // Clear ignored in RUN; clear+start_stop together in PAUSE clears.
        hold(1'b0, 1'b1, 1);
        hold(1'b0, 1'b0, DEBOUNCE + 4);
        check_bit("clear_ignored_in_run", running, 1'b1);
        press_ss();
        hold(1'b1, 1'b1, 1);
        hold(1'b0, 1'b0, DEBOUNCE + 4);
        check("clear_wins_in_pause", {3'b0, running, digs()}, 28'd0);

        // Overflow wrap from a preloaded 59:59.98.
        press_ss();
        press_ss();
        force dut.r_min_tens = 4'd5;
        force dut.r_min_ones = 4'd9;
        force dut.r_sec_tens = 4'd5;
        force dut.r_sec_ones = 4'd9;
        force dut.r_hs_tens  = 4'd9;
        force dut.r_hs_ones  = 4'd8;
        m_t = WRAP_T - 2;
        cycle(1'b0, 1'b0);
        release dut.r_min_tens;
        release dut.r_min_ones;
        release dut.r_sec_tens;
        release dut.r_sec_ones;
        release dut.r_hs_tens;
        release dut.r_hs_ones;
        cycle(1'b0, 1'b0);
        hold(1'b1, 1'b0, 1);
        ticks = 0;
        for (int i = 0; i < 20 && ticks < 2; i++) begin
            cycle(1'b0, 1'b0);
            if (tick) begin
                ticks++;
                if (ticks == 1) check("wrap_59_59_99", {4'h0, digs()}, {4'h0, 24'h595999});
                else            check("wrap_to_zero_ovf", {3'b0, overflow, digs()}, {3'b0, 1'b1, 24'h0});
            end
        end
        check("wrap_tick_count", 28'(ticks), 28'd2);
        press_ss();
        hold(1'b0, 1'b1, 1);
        hold(1'b0, 1'b0, DEBOUNCE + 4);
        check_bit("overflow_cleared", overflow, 1'b0);

        // Asynchronous reset between edges while running.
        press_ss();
        hold(1'b0, 1'b0, 7);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", dut_vec(), 28'd0);
        model_reset();
        hold(1'b0, 1'b0, 2);
        reset = 1'b0;

        // Random button activity against the model.
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 7));
            n = int'($urandom_range(1, 6));
            hold((r < 2), (r == 2), n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch datapath. Conditions the start/stop and clear buttons, runs an IDLE/RUN/PAUSE state machine, and owns the prescaler that turns `clock_in` into a hundredths-of-a-second tick. It maintains the six BCD time digits and drives the enable of the downstream display-refresh clock divider.

## Interface
- `TICK_DIV`, default 1_000_000: `clock_in` cycles per hundredth-second tick (100 MHz → 100 Hz). Must be ≥ 2.
- `DEBOUNCE`, default 2_000_000: lockout cycles after an accepted button edge (20 ms at 100 MHz). Must be ≥ 1.
- `clock_in` in 1: the single system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start_stop` in 1: raw, asynchronous push-button level.
- `clear` in 1: raw, asynchronous push-button level.
- `running` out 1: 1 only in RUN.
- `div_enable` out 1: equals `running`; drives the clock divider `enable`.
- `tick` out 1: one-cycle pulse per hundredth second.
- `hs_ones`, `hs_tens`, `sec_ones`, `sec_tens`, `min_ones`, `min_tens` out 4 each: BCD time, MM:SS.hh.
- `overflow` out 1: sticky; set on wrap past 59:59.99.

## Operation
- Reset values: state IDLE; `running`, `div_enable`, `tick`, `overflow` = 0; all digits 0; prescaler 0; synchronizers and debounce lockouts cleared.
- Button path, per input: 2-flop synchronizer, then rising-edge detect on the synchronized level.
  - An edge is accepted only when the lockout counter is 0.
  - An accepted edge loads the lockout with `DEBOUNCE`, which counts down to 0.
  - Edges during lockout are dropped. Held buttons give exactly one event.
- State machine, on accepted events:
  - IDLE: start_stop → RUN. clear → IDLE (no-op).
  - RUN: start_stop → PAUSE. clear is ignored.
  - PAUSE: start_stop → RUN. clear → IDLE; zeroes digits, prescaler and `overflow`.
- Simultaneous events in the same cycle:
  - In IDLE or PAUSE, clear wins; start_stop is discarded.
  - In RUN, start_stop wins.
- Prescaler width is `$clog2(TICK_DIV)`.
  - RUN: counts 0..`TICK_DIV`-1. At `TICK_DIV`-1 it wraps to 0 and `tick` is registered high for exactly one cycle.
  - PAUSE: holds its value, so a resume keeps the fractional hundredth.
  - IDLE: held at 0.
- Digit update on each tick:
  - `hs_ones` increments. 9 → 0 carries to `hs_tens`; 9 → 0 carries to `sec_ones`.
  - `sec_ones` 9 → 0 carries to `sec_tens`; 5 → 0 carries to `min_ones`.
  - `min_ones` 9 → 0 carries to `min_tens`.
  - 59:59.99 → 00:00.00 sets `overflow`; the state stays in RUN.
- Digits never hold non-BCD values.

## Timing
- If a raw button goes high with setup met before clock edge 1, the event is detected after edge 2 and `running` changes on edge 3.
- Digits update on the same edge where `tick` goes high.
- `tick` period in uninterrupted RUN is exactly `TICK_DIV` cycles.
  - First tick comes `TICK_DIV` cycles after the edge that enters RUN from IDLE.
  - After a resume from PAUSE, the first tick comes after the remaining `TICK_DIV` − held-count cycles.
- A pause taking effect on the same edge as a tick still applies that tick, and that tick pulse appears. The prescaler then holds at 0.
- `div_enable` and `running` are registered and change on the same edge as the state.
- Reset asserted mid-count forces all reset values immediately, asynchronously. Release is sampled on the next rising edge.

## Structure
- Package `stopwatch_pkg`:
  - state enum `sw_state_t` {IDLE, RUN, PAUSE};
  - `bcd_t` (4-bit);
  - constants `HS_MAX`=9, `TENS_SEC_MAX`=5, `TENS_MIN_MAX`=5.
- Sub-module `btn_sync_edge` (parameter `DEBOUNCE`; ports `clock_in`, `reset`, `btn_raw`, `btn_event`).
  - Holds the synchronizer, edge detect and lockout.
  - Instantiated twice, for start_stop and clear.
- Top level holds the FSM, prescaler and BCD cascade.

## Test plan
All scenarios use `TICK_DIV`=4 and `DEBOUNCE`=8.
- Reset, then pulse start_stop → `running`=1 on the 3rd edge; first `tick` 4 cycles later; after 40 ticks digits read 00:00.40.
- Bounce start_stop (high 1, low 1, high 3 cycles) inside the lockout → exactly one event; state goes to RUN, not back to PAUSE.
- RUN with prescaler at 2: pause, wait 50 cycles, resume → next `tick` exactly 2 cycles after the resume edge; digits unchanged during the pause.
- Clear during RUN → ignored. Clear and start_stop in the same cycle during PAUSE → IDLE, digits 00:00.00, `running`=0.
- Preload 59:59.98 and run 2 ticks → 59:59.99, then 00:00.00 with `overflow`=1. A subsequent pause+clear → `overflow`=0.
- Assert `reset` asynchronously mid-RUN between clock edges → all outputs 0 before the next edge.
